// File: rtl/shift_ctrl_pkg.sv
// Shared types for the shift request arbiter.
//   op_e    : shift/rotate operation encoding carried on each request port
//   state_e : output register occupancy (EMPTY = free, FULL = holds a result)
//   NUM_REQ : number of requesters sharing the shifter datapath
package shift_ctrl_pkg;

  typedef enum logic [1:0] {
    SHR = 2'd0,
    SHL = 2'd1,
    ROR = 2'd2,
    ROL = 2'd3
  } op_e;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  localparam int NUM_REQ = 2;

endpackage

// File: rtl/param_left_shifter.sv
// Logical left shifter with zero fill.
//   a   : operand, 2**N bits
//   amt : shift amount, N bits
//   y   : a << amt
module param_left_shifter #(
  parameter int N = 3
) (
  input  logic [(2**N)-1:0] a,
  input  logic [N-1:0]      amt,
  output logic [(2**N)-1:0] y
);

  assign y = a << amt;

endmodule

// File: rtl/param_right_shifter.sv
// Logical right shifter with zero fill.
//   a   : operand, 2**N bits
//   amt : shift amount, N bits
//   y   : a >> amt
module param_right_shifter #(
  parameter int N = 3
) (
  input  logic [(2**N)-1:0] a,
  input  logic [N-1:0]      amt,
  output logic [(2**N)-1:0] y
);

  assign y = a >> amt;

endmodule

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter.
//   clk, rst_n : clock, async active-low reset
//   req        : request vector (bit i = port i)
//   advance    : a granted request completed its handshake this cycle
//   grant      : one-hot grant (combinational), 2'b00 when nothing requests
// prio_q names the port preferred on a tie. After a completed handshake it
// moves to the port that did not win, so the last winner yields next time.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic prio_q;
  logic prio_d;

  // Grant selection: lone requester wins, ties go to the preferred port.
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = prio_q ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  // Next preference: the loser of a completed handshake is preferred next.
  always_comb begin
    prio_d = prio_q;
    if (advance) begin
      prio_d = grant[1] ? 1'b0 : 1'b1;
    end else begin
      prio_d = prio_q;
    end
  end

  // Preference register, port 0 preferred out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/shift_req_arbiter.sv
// Two requesters share one right/left shifter pair. A round-robin arbiter picks
// the winner, its operand is shifted/rotated and captured in a single response
// register tagged with the winner's id.
//   clk, rst_n : clock, async active-low reset
//   req_valid/req_ready/req_data/req_amt/req_op : per-port request handshake
//   rsp_valid/rsp_ready/rsp_data/rsp_id         : registered response handshake
//   done_cnt   : per-port saturating count of drained responses
module shift_req_arbiter
  import shift_ctrl_pkg::*;
#(
  parameter int N     = 3,
  parameter int CNT_W = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_REQ-1:0]                req_valid,
  output logic [NUM_REQ-1:0]                req_ready,
  input  logic [NUM_REQ-1:0][(2**N)-1:0]    req_data,
  input  logic [NUM_REQ-1:0][N-1:0]         req_amt,
  input  logic [NUM_REQ-1:0][1:0]           req_op,
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic [(2**N)-1:0]                 rsp_data,
  output logic                              rsp_id,
  output logic [NUM_REQ-1:0][CNT_W-1:0]     done_cnt
);

  localparam int WIDTH = 2**N;

  state_e                          state_q, state_d;
  logic                            rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]                rsp_data_q, rsp_data_d;
  logic                            rsp_id_q, rsp_id_d;
  logic [NUM_REQ-1:0][CNT_W-1:0]   done_cnt_q, done_cnt_d;

  logic [NUM_REQ-1:0] grant_s;
  logic [NUM_REQ-1:0] hs_s;
  logic               can_accept_s;
  logic               advance_s;
  logic               drain_s;
  logic               win_id_s;
  logic [WIDTH-1:0]   win_data_s;
  logic [N-1:0]       win_amt_s;
  logic [N-1:0]       win_amt_neg_s;
  op_e                win_op_s;
  logic [N-1:0]       right_amt_s;
  logic [N-1:0]       left_amt_s;
  logic [WIDTH-1:0]   right_y_s;
  logic [WIDTH-1:0]   left_y_s;
  logic [WIDTH-1:0]   result_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + CNT_W'(1);
    end
  endfunction

  rr_arbiter2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_valid),
    .advance (advance_s),
    .grant   (grant_s)
  );

  // The output register can take a new result when empty or when its current
  // result leaves this same cycle. rst_n gates ready so nothing is accepted in reset.
  assign can_accept_s = (state_q == EMPTY) | (rsp_valid_q & rsp_ready);
  assign req_ready    = grant_s & {NUM_REQ{can_accept_s & rst_n}};
  assign hs_s         = req_valid & req_ready;
  assign advance_s    = |hs_s;
  assign drain_s      = rsp_valid_q & rsp_ready;
  assign win_id_s     = grant_s[1];

  // Operand mux: steer the granted port into the shared datapath.
  always_comb begin
    win_data_s    = req_data[win_id_s];
    win_amt_s     = req_amt[win_id_s];
    win_op_s      = op_e'(req_op[win_id_s]);
    // N-bit negation is (-amt) mod WIDTH, the complementary rotate distance.
    win_amt_neg_s = {N{1'b0}} - win_amt_s;
  end

  // Shift amounts: a rotate uses both shifters, one by amt and the other by
  // the complementary distance; amt=0 makes both halves equal to the operand.
  always_comb begin
    right_amt_s = win_amt_s;
    left_amt_s  = win_amt_s;
    case (win_op_s)
      ROR:     left_amt_s  = win_amt_neg_s;
      ROL:     right_amt_s = win_amt_neg_s;
      default: begin
        right_amt_s = win_amt_s;
        left_amt_s  = win_amt_s;
      end
    endcase
  end

  param_right_shifter #(.N(N)) u_rshift (
    .a   (win_data_s),
    .amt (right_amt_s),
    .y   (right_y_s)
  );

  param_left_shifter #(.N(N)) u_lshift (
    .a   (win_data_s),
    .amt (left_amt_s),
    .y   (left_y_s)
  );

  // Result select: plain shifts take one shifter, rotates OR both.
  always_comb begin
    result_s = right_y_s;
    case (win_op_s)
      SHR:     result_s = right_y_s;
      SHL:     result_s = left_y_s;
      ROR:     result_s = right_y_s | left_y_s;
      ROL:     result_s = right_y_s | left_y_s;
      default: result_s = right_y_s;
    endcase
  end

  // Output FSM next state: capture on handshake, free on drain, else hold.
  always_comb begin
    state_d     = state_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    case (state_q)
      EMPTY: begin
        if (advance_s) begin
          state_d     = FULL;
          rsp_valid_d = 1'b1;
          rsp_data_d  = result_s;
          rsp_id_d    = win_id_s;
        end else begin
          state_d     = EMPTY;
          rsp_valid_d = 1'b0;
        end
      end
      FULL: begin
        if (advance_s) begin
          // Drain and refill in the same cycle keeps the register full.
          state_d     = FULL;
          rsp_valid_d = 1'b1;
          rsp_data_d  = result_s;
          rsp_id_d    = win_id_s;
        end else if (rsp_ready) begin
          state_d     = EMPTY;
          rsp_valid_d = 1'b0;
        end else begin
          state_d     = FULL;
          rsp_valid_d = 1'b1;
        end
      end
      default: begin
        state_d     = EMPTY;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // Completion counters: bump the drained response's port, saturating.
  always_comb begin
    done_cnt_d = done_cnt_q;
    if (drain_s) begin
      done_cnt_d[rsp_id_q] = sat_inc(done_cnt_q[rsp_id_q]);
    end else begin
      done_cnt_d = done_cnt_q;
    end
  end

  // Output FSM and response registers; reset drops any held result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= {WIDTH{1'b0}};
      rsp_id_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  // Completion counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_cnt_q <= {(NUM_REQ*CNT_W){1'b0}};
    end else begin
      done_cnt_q <= done_cnt_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign done_cnt  = done_cnt_q;

endmodule

// File: tb/tb_shift_req_arbiter.sv
// Directed bench for shift_req_arbiter (N=3), plus a CNT_W=2 copy sharing the
// same stimulus to observe counter saturation.
module tb_shift_req_arbiter;
  import shift_ctrl_pkg::*;

  logic              clk;
  logic              rst_n;
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [1:0][7:0]   req_data;
  logic [1:0][2:0]   req_amt;
  logic [1:0][1:0]   req_op;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [7:0]        rsp_data;
  logic              rsp_id;
  logic [1:0][15:0]  done_cnt;

  logic [1:0]        s_req_ready;
  logic              s_rsp_valid;
  logic [7:0]        s_rsp_data;
  logic              s_rsp_id;
  logic [1:0][1:0]   s_done_cnt;

  int total;
  int bad;

  shift_req_arbiter #(.N(3), .CNT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .req_amt   (req_amt),
    .req_op    (req_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .done_cnt  (done_cnt)
  );

  shift_req_arbiter #(.N(3), .CNT_W(2)) dut_sat (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (s_req_ready),
    .req_data  (req_data),
    .req_amt   (req_amt),
    .req_op    (req_op),
    .rsp_valid (s_rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (s_rsp_data),
    .rsp_id    (s_rsp_id),
    .done_cnt  (s_done_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One isolated request on a port with rsp_ready already high, then drain it.
  task automatic do_one(input int port, input logic [1:0] op, input logic [2:0] amt,
                        input logic [7:0] exp, input string tag);
    req_data[port] = 8'hB3;
    req_amt[port]  = amt;
    req_op[port]   = op;
    req_valid      = 2'b00;
    req_valid[port] = 1'b1;
    tick();
    req_valid = 2'b00;
    chk({tag, "_data"}, {24'd0, rsp_data}, {24'd0, exp});
    chk({tag, "_id"}, {31'd0, rsp_id}, port);
    chk({tag, "_vld"}, {31'd0, rsp_valid}, 32'd1);
    tick();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n     = 1'b0;
    req_valid = 2'b11;
    req_data  = {8'hB3, 8'hB3};
    req_amt   = {3'd0, 3'd0};
    req_op    = {SHR, SHR};
    rsp_ready = 1'b0;

    // Reset state, with both ports requesting.
    #12;
    chk("rst_vld", {31'd0, rsp_valid}, 32'd0);
    chk("rst_data", {24'd0, rsp_data}, 32'd0);
    chk("rst_id", {31'd0, rsp_id}, 32'd0);
    chk("rst_cnt", done_cnt, 32'd0);
    chk("rst_rdy", {30'd0, req_ready}, 32'd0);
    rst_n = 1'b1;

    // Port 0 SHR 3, response held while rsp_ready low, then drained.
    req_valid  = 2'b01;
    req_amt[0] = 3'd3;
    req_op[0]  = SHR;
    #1;
    chk("p0_rdy", {30'd0, req_ready}, 32'd1);
    chk("p0_pre_vld", {31'd0, rsp_valid}, 32'd0);
    tick();
    req_valid = 2'b00;
    chk("p0_vld", {31'd0, rsp_valid}, 32'd1);
    chk("p0_data", {24'd0, rsp_data}, 32'h16);
    chk("p0_id", {31'd0, rsp_id}, 32'd0);
    rsp_ready = 1'b1;
    tick();
    chk("p0_drained", {31'd0, rsp_valid}, 32'd0);
    chk("p0_cnt", {16'd0, done_cnt[0]}, 32'd1);

    // Port 1 ops, including amt=0 and the maximum amount.
    do_one(1, SHL, 3'd3, 8'h98, "shl3");
    do_one(1, ROR, 3'd3, 8'h76, "ror3");
    do_one(1, ROL, 3'd3, 8'h9D, "rol3");
    do_one(1, SHR, 3'd0, 8'hB3, "shr0");
    do_one(1, SHL, 3'd0, 8'hB3, "shl0");
    do_one(1, ROR, 3'd0, 8'hB3, "ror0");
    do_one(1, ROL, 3'd0, 8'hB3, "rol0");
    do_one(1, ROR, 3'd7, 8'h67, "ror7");
    do_one(1, SHR, 3'd7, 8'h01, "shr7");
    chk("p1_cnt", {16'd0, done_cnt[1]}, 32'd9);

    // Both ports continuously valid: alternate 0,1,0,1 at one per cycle.
    req_data  = {8'hB3, 8'hB3};
    req_amt   = {3'd1, 3'd1};
    req_op    = {SHL, SHR};
    req_valid = 2'b11;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("alt_id", {31'd0, rsp_id}, k & 1);
      chk("alt_data", {24'd0, rsp_data}, ((k & 1) != 0) ? 32'h66 : 32'h59);
    end
    req_valid = 2'b00;
    tick();
    chk("alt_cnt0", {16'd0, done_cnt[0]}, 32'd5);
    chk("alt_cnt1", {16'd0, done_cnt[1]}, 32'd13);

    // Stall: FULL with rsp_ready low for 5 cycles while port 1 waits.
    rsp_ready  = 1'b0;
    req_amt[0] = 3'd3;
    req_op[0]  = ROL;
    req_amt[1] = 3'd2;
    req_op[1]  = SHR;
    req_valid  = 2'b01;
    tick();
    req_valid = 2'b10;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("stall_data", {24'd0, rsp_data}, 32'h9D);
      chk("stall_id", {31'd0, rsp_id}, 32'd0);
      chk("stall_rdy", {30'd0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    #1;
    chk("drain_acc_rdy", {30'd0, req_ready}, 32'd2);
    tick();
    chk("drain_acc_id", {31'd0, rsp_id}, 32'd1);
    chk("drain_acc_data", {24'd0, rsp_data}, 32'h2C);
    chk("drain_acc_vld", {31'd0, rsp_valid}, 32'd1);
    chk("drain_acc_cnt0", {16'd0, done_cnt[0]}, 32'd6);
    req_valid = 2'b00;
    tick();
    chk("drain_cnt1", {16'd0, done_cnt[1]}, 32'd14);

    // Asynchronous reset while FULL.
    rsp_ready  = 1'b0;
    req_amt[0] = 3'd1;
    req_op[0]  = SHL;
    req_valid  = 2'b01;
    tick();
    chk("pre_rst_vld", {31'd0, rsp_valid}, 32'd1);
    req_valid = 2'b11;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_vld", {31'd0, rsp_valid}, 32'd0);
    chk("arst_cnt", done_cnt, 32'd0);
    chk("arst_rdy", {30'd0, req_ready}, 32'd0);
    #1;
    rst_n = 1'b1;
    #1;
    chk("post_rst_rdy", {30'd0, req_ready}, 32'd1);
    tick();
    chk("post_rst_id", {31'd0, rsp_id}, 32'd0);
    chk("post_rst_vld", {31'd0, rsp_valid}, 32'd1);

    // Saturation: six port-0 responses drained.
    rsp_ready = 1'b1;
    req_valid = 2'b01;
    for (int k = 0; k < 5; k++) begin
      tick();
    end
    req_valid = 2'b00;
    tick();
    chk("sat_main_cnt0", {16'd0, done_cnt[0]}, 32'd6);
    chk("sat_cnt0", {30'd0, s_done_cnt[0]}, 32'd3);
    chk("sat_cnt1", {30'd0, s_done_cnt[1]}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
